// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Multicycle byte-addressable memory on a req/ready handshake with a
//            fixed LATENCY; optional misalignment trap via
//            MEM_RESPONDER_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         c_AW      = $clog2(DEPTH_WORDS);
  localparam int         c_CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CW-1:0]    r_cnt;
  logic               r_we;
  logic [1:0]         r_size;
  logic [c_AW+1:0]    r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_access;
  logic               w_acc_we;
  logic [1:0]         w_acc_size;
  logic [c_AW+1:0]    w_acc_addr;
  logic [31:0]        w_acc_wdata;
  logic [c_AW-1:0]    w_idx;
  logic [3:0]         w_lane_en;
  logic [31:0]        w_wdata_rep;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_rd_data;
  logic [31:0]        w_rsp_data;
  logic               w_err_acc;
  logic               w_mem_we;
  logic               w_unused;

  assign w_unused = &{1'b0, addr[31:c_AW+2]};

  // With LATENCY=1 the access happens on the acceptance edge, so the live
  // inputs feed the datapath in IDLE; otherwise the captured request does.
  always_comb begin
    w_accept = (r_state == S_IDLE) && req;
    if (r_state == S_IDLE) begin
      w_acc_we    = we;
      w_acc_size  = size;
      w_acc_addr  = addr[c_AW+1:0];
      w_acc_wdata = wdata;
    end else begin
      w_acc_we    = r_we;
      w_acc_size  = r_size;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
    if (LATENCY == 1) begin
      w_access = w_accept;
    end else begin
      w_access = (r_state == S_WAIT) && (r_cnt == c_CW'(1));
    end
    w_idx = w_acc_addr[c_AW+1:2];
  end

  always_comb begin
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    w_err_acc = ((w_acc_size == c_SZ_HALF) && w_acc_addr[0]) ||
                ((w_acc_size[1] == w_acc_size[0]) && (w_acc_addr[1:0] != 2'b00));
`else
    w_err_acc = 1'b0;
`endif
  end

  always_comb begin
    w_rd_word = r_mem[w_idx];
    case (w_acc_size)
      c_SZ_BYTE: begin
        w_lane_en   = 4'b0001 << w_acc_addr[1:0];
        w_wdata_rep = {4{w_acc_wdata[7:0]}};
        w_rd_data   = {24'd0, w_rd_word[{w_acc_addr[1:0], 3'b000} +: 8]};
      end
      c_SZ_HALF: begin
        w_lane_en   = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{w_acc_wdata[15:0]}};
        w_rd_data   = {16'd0, (w_acc_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0])};
      end
      default: begin
        w_lane_en   = 4'b1111;
        w_wdata_rep = w_acc_wdata;
        w_rd_data   = w_rd_word;
      end
    endcase
    w_rsp_data = (w_acc_we || w_err_acc) ? 32'd0 : w_rd_data;
    w_mem_we   = w_access && w_acc_we && !w_err_acc && !reset;
  end

  // Array is deliberately outside the reset domain; reset only blocks the commit.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= we;
            r_size  <= size;
            r_addr  <= addr[c_AW+1:0];
            r_wdata <= wdata;
            r_cnt   <= c_CW'(LATENCY - 1);
            busy    <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              ready   <= 1'b1;
              rdata   <= w_rsp_data;
              err     <= w_err_acc;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - c_CW'(1);
          if (w_access) begin
            r_state <= S_RESP;
            ready   <= 1'b1;
            rdata   <= w_rsp_data;
            err     <= w_err_acc;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          ready   <= 1'b0;
          busy    <= 1'b0;
          rdata   <= 32'd0;
          err     <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          ready   <= 1'b0;
          busy    <= 1'b0;
          rdata   <= 32'd0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multicycle memory responder on a req/ready handshake. The CPU control unit is the initiator: it issues one word, halfword or byte access and waits for `ready`.
- Holds an internal byte-addressable, word-organised array.
- Inserts a fixed, parameterised latency so the control FSM can be exercised against wait states.
- Sits in place of the single-cycle memory, between the address/store-data muxes and the load path.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array (power of two, ≥4).
- LATENCY, 2, cycles from request acceptance to `ready` (≥1).

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  access request; sampled only when `busy`=0
- we  input  1  1 = write, 0 = read; sampled with `req`
- size  input  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
- addr  input  32  byte address; sampled with `req`
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rdata  output  32  load data, right-aligned, zero-extended; valid only while `ready`=1
- ready  output  1  one-cycle completion pulse
- busy  output  1  high from the cycle after acceptance through the `ready` cycle
- err  output  1  misalignment flag; valid only while `ready`=1

Behaviour:
- Reset: state IDLE; `rdata`=0, `ready`=0, `busy`=0, `err`=0; latency counter=0; captured request fields=0.
  - Array contents are not affected by reset.
  - Reset in any state aborts the access. A write not yet committed is discarded.
- Word index = `addr`[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored (addresses wrap modulo 4*DEPTH_WORDS).
- Byte lanes are little-endian: `addr`[1:0]=0 selects bits [7:0].
  - Halfword uses `addr`[1]: 0 selects [15:0], 1 selects [31:16].
- FSM states IDLE, WAIT, RESP:
  - IDLE: `busy`=0.
    - If `req`=1 at an edge, latch `we`/`size`/`addr`/`wdata`, load counter = LATENCY-1, go to WAIT, or to RESP directly if LATENCY=1.
  - WAIT: `busy`=1. Counter decrements each cycle. When the counter reaches 0 at an edge, perform the access and go to RESP.
  - RESP: `busy`=1, `ready`=1 for exactly one cycle; the next edge returns to IDLE.
- Access at the WAIT→RESP edge:
  - Read: registers `rdata`.
  - Write: updates only the addressed lanes. Word writes all 4 lanes, half writes 2 lanes, byte writes 1 lane; `rdata` = 0.
- Timing:
  - Request accepted at edge E → `ready` high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - A new request can be accepted at the edge that ends the RESP cycle at the earliest only if presented in IDLE. `req` in RESP is ignored, so back-to-back throughput is one access per LATENCY+1 cycles.
- `req` while `busy`=1 is ignored; no queuing.
- Write followed by read of the same address returns the new data.
- After `ready`, `rdata` and `err` return to 0 in the next cycle.

Optional Feature:
- Macro MEM_RESPONDER_ALIGN_CHECK_EN.
- Defined:
  - Word with `addr`[1:0]≠0, or half with `addr`[0]=1, is misaligned.
  - Misaligned accesses keep normal timing, perform no array access (writes suppressed), and give `rdata`=0, `err`=1 in the `ready` cycle.
- Undefined:
  - `err` tied to 0.
  - Word ignores `addr`[1:0]; half ignores `addr`[0].

Test Plan:
- Reset then idle, no `req` → `ready`=0, `busy`=0, `err`=0, `rdata`=0 for 10 cycles.
- LATENCY=2. Word write `addr`=0x10, `wdata`=0xDEADBEEF; then word read 0x10 → `ready` 2 cycles after each acceptance, `busy` high 2 cycles each; read `rdata`=0xDEADBEEF.
- Lane writes on word 0x20 holding 0x11223344:
  - Byte write 0xAA to 0x21 → word read gives 0x1122AA44.
  - Half write 0x5566 to 0x22 → word read gives 0x5566AA44.
  - Byte read 0x23 → `rdata`=0x00000055.
- Hold `req`=1 continuously across two reads (0x00, 0x04) → second accepted only after RESP; `ready` pulses spaced LATENCY+1=3 cycles; extra `req` during `busy` causes no additional pulse.
- Assert `reset` in WAIT of a word write of 0xCAFEF00D to 0x30, word previously 0x0 → no `ready`; subsequent read of 0x30 returns 0x00000000.
- With MEM_RESPONDER_ALIGN_CHECK_EN, word write to 0x31 → `ready` with `err`=1, `rdata`=0; word read 0x30 unchanged. Without the macro: same write lands at 0x30.
